// File: rtl/mtr_duty_sched_if.sv
// mtr_duty_sched_if
//   Bundles every non-clock signal between a motor-channel controller and the
//   duty-cycle scheduler: the PWM period tick, the drive enable, the target
//   request handshake and the scheduled duty/direction outputs.
//   master : controller side (drives synch/enable/requests, observes outputs)
//   slave  : scheduler side
//   Signals:
//     PWM_synch   1-clk pulse from the PWM generator, once per PWM period
//     en          drive enable, low forces duty to 0 (emergency stop)
//     req_valid   new target present
//     req_ready   scheduler can accept a target
//     req_duty    target duty magnitude (11 bits)
//     req_rev     target direction (1 = reverse)
//     duty        registered duty to the PWM generator
//     rev         registered direction to the bridge driver
//     busy        scheduler is not idle
//     at_target   idle, enabled and outputs equal the latched target
interface mtr_duty_sched_if;
  logic        PWM_synch;
  logic        en;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_duty;
  logic        req_rev;
  logic [10:0] duty;
  logic        rev;
  logic        busy;
  logic        at_target;

  modport master (
    output PWM_synch, en, req_valid, req_duty, req_rev,
    input  req_ready, duty, rev, busy, at_target
  );

  modport slave (
    input  PWM_synch, en, req_valid, req_duty, req_rev,
    output req_ready, duty, rev, busy, at_target
  );
endinterface

// File: rtl/mtr_duty_sched.sv
// mtr_duty_sched
//   Slew-limited duty scheduler in front of an 11-bit PWM generator. Targets
//   are latched through a valid/ready handshake and the output duty walks
//   toward them by at most STEP LSBs per PWM period, only on PWM_synch.
//   Direction reversals brake to zero, hold zero for DEAD_PERIODS periods,
//   flip the direction bit and then ramp back up, so the bridge never sees
//   a direction change while driving.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    mtr_duty_sched_if.slave (synch, enable, request, duty outputs)
module mtr_duty_sched #(
  parameter int STEP         = 16,
  parameter int DEAD_PERIODS = 4
) (
  input logic              clk,
  input logic              rst_n,
  mtr_duty_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} state_t;

  localparam int          CW        = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_PERIODS - 1);
  localparam logic [11:0] STEP_X    = 12'(STEP);

  state_t        r_state;
  logic [10:0]   r_duty;
  logic          r_rev;
  logic [10:0]   r_tgtDuty;
  logic          r_tgtRev;
  logic [CW-1:0] r_deadCnt;

  state_t        w_nextState;
  logic [10:0]   w_nextDuty;
  logic          w_nextRev;
  logic [CW-1:0] w_nextDeadCnt;

  logic          w_busy;
  logic          w_reqReady;
  logic          w_atTarget;
  logic          w_accept;

  logic [11:0]   w_dutyX;
  logic [11:0]   w_tgtX;
  logic          w_goingUp;
  logic [11:0]   w_gap;
  logic [11:0]   w_rampStep;
  logic [11:0]   w_rampDuty;
  logic [11:0]   w_brakeStep;
  logic [11:0]   w_brakeDuty;

  // Saturate a 12-bit intermediate back into the 11-bit duty range.
  function automatic logic [10:0] clampDuty(input logic [11:0] v);
    clampDuty = v[11] ? 11'h7FF : v[10:0];
  endfunction

  assign w_accept = bus.req_valid && w_reqReady;

  // Candidate next duties for a ramp toward the target and for a brake
  // toward zero. The step is clipped to the remaining gap, so the result
  // lands exactly on the target or zero and cannot overshoot or wrap.
  always_comb begin
    w_dutyX     = {1'b0, r_duty};
    w_tgtX      = {1'b0, r_tgtDuty};
    w_goingUp   = (w_tgtX >= w_dutyX);
    w_gap       = w_goingUp ? (w_tgtX - w_dutyX) : (w_dutyX - w_tgtX);
    w_rampStep  = (w_gap > STEP_X) ? STEP_X : w_gap;
    w_rampDuty  = w_goingUp ? (w_dutyX + w_rampStep) : (w_dutyX - w_rampStep);
    w_brakeStep = (w_dutyX > STEP_X) ? STEP_X : w_dutyX;
    w_brakeDuty = w_dutyX - w_brakeStep;
  end

  // State register. Targets load on an accepted request independently of
  // the PWM tick; everything else follows the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_duty    <= '0;
      r_rev     <= 1'b0;
      r_tgtDuty <= '0;
      r_tgtRev  <= 1'b0;
      r_deadCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_duty    <= w_nextDuty;
      r_rev     <= w_nextRev;
      r_deadCnt <= w_nextDeadCnt;
      if (w_accept) begin
        r_tgtDuty <= bus.req_duty;
        r_tgtRev  <= bus.req_rev;
      end
    end
  end

  // Next-state logic. Dropping en overrides everything on the very next
  // clock; otherwise the state only advances on a PWM tick and always uses
  // the target that was latched before this edge. IDLE, RAMP and BRAKE share
  // one rule: a direction mismatch brakes, a match ramps toward the target,
  // which also covers a reversal request that is withdrawn mid-brake.
  always_comb begin
    w_nextState   = r_state;
    w_nextDuty    = r_duty;
    w_nextRev     = r_rev;
    w_nextDeadCnt = r_deadCnt;
    if (!bus.en) begin
      w_nextState   = DEAD;
      w_nextDuty    = '0;
      w_nextDeadCnt = '0;
    end else if (bus.PWM_synch) begin
      case (r_state)
        IDLE, RAMP, BRAKE: begin
          if (r_tgtRev != r_rev) begin
            w_nextDuty = clampDuty(w_brakeDuty);
            if (w_brakeDuty == 12'd0) begin
              w_nextState   = DEAD;
              w_nextDeadCnt = '0;
            end else begin
              w_nextState = BRAKE;
            end
          end else begin
            w_nextDuty  = clampDuty(w_rampDuty);
            w_nextState = (w_rampDuty == w_tgtX) ? IDLE : RAMP;
          end
        end
        DEAD: begin
          if (r_deadCnt == DEAD_LAST) begin
            w_nextRev     = r_tgtRev;
            w_nextDeadCnt = '0;
            w_nextState   = (r_tgtDuty == 11'd0) ? IDLE : RAMP;
          end else begin
            w_nextDeadCnt = r_deadCnt + CW'(1);
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state and registers.
  always_comb begin
    w_busy     = (r_state != IDLE);
    w_reqReady = (r_state != DEAD);
    w_atTarget = (r_state == IDLE) && bus.en &&
                 (r_duty == r_tgtDuty) && (r_rev == r_tgtRev);
  end

  assign bus.duty      = r_duty;
  assign bus.rev       = r_rev;
  assign bus.busy      = w_busy;
  assign bus.req_ready = w_reqReady;
  assign bus.at_target = w_atTarget;

endmodule
